// File: rtl/ram_port_pkg.sv
// Shared types and constants for the RAM port initiator.
package ram_port_pkg;

  // CLEAR zero-fills the RAM after reset; RUN serves commands until the next reset.
  typedef enum logic {CLEAR, RUN} ram_port_state_t;

  // Reads accepted but not yet popped; also the response FIFO depth.
  localparam int OCC_MAX = 2;

endpackage

// File: rtl/ram_rsp_fifo2.sv
// Two-entry response FIFO. It buffers read data against response backpressure.
module ram_rsp_fifo2 #(
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [D_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic               valid,
  output logic               full,
  output logic [D_WIDTH-1:0] data
);

  logic [D_WIDTH-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_push;
  logic               w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & valid;
  assign valid  = (r_count != 2'd0);
  assign full   = (r_count == 2'd2);
  assign data   = r_mem[r_rd_ptr];

  // Storage is not reset; only the pointers and count say what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and count update; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_initiator.sv
// Initiator side of the RAM port: zero-fills the RAM after reset, then turns
// single-beat read/write commands into RAM accesses and returns read data in order.
module ram_port_initiator
  import ram_port_pkg::*;
#(
  parameter int A_WIDTH = 3,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               init_done,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wr,
  input  logic [A_WIDTH-1:0] cmd_add,
  input  logic [D_WIDTH-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [D_WIDTH-1:0] rsp_data,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_w_add,
  output logic [D_WIDTH-1:0] mem_w_data,
  output logic [A_WIDTH-1:0] mem_r_add,
  input  logic [D_WIDTH-1:0] mem_r_data
);

  localparam logic [A_WIDTH-1:0] CLR_LAST = '1;

  ram_port_state_t    r_state;
  ram_port_state_t    w_state_next;
  logic [A_WIDTH-1:0] r_clr_cnt;
  logic [1:0]         r_occ;
  logic               r_rd_pend;
  logic               w_accept;
  logic               w_rd_accept;
  logic               w_pop;
  logic               w_fifo_full;

  assign w_rd_accept = w_accept & ~cmd_wr;
  assign w_pop       = rsp_valid & rsp_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= CLEAR;
    else       r_state <= w_state_next;
  end

  // Next state and RAM/command muxing. cmd_ready depends only on registered state and occupancy.
  always_comb begin
    w_state_next = r_state;
    init_done    = 1'b0;
    cmd_ready    = 1'b0;
    w_accept     = 1'b0;
    mem_we       = 1'b0;
    mem_w_add    = cmd_add;
    mem_w_data   = cmd_data;
    mem_r_add    = cmd_add;
    case (r_state)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_w_add  = r_clr_cnt;
        mem_w_data = '0;
        if (r_clr_cnt == CLR_LAST) w_state_next = RUN;
      end
      RUN: begin
        init_done = 1'b1;
        cmd_ready = (r_occ < 2'(OCC_MAX));
        w_accept  = cmd_valid & (r_occ < 2'(OCC_MAX));
        mem_we    = w_accept & cmd_wr;
      end
      default: w_state_next = CLEAR;
    endcase
  end

  // Fill counter, read-pending flag and read occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt <= '0;
      r_occ     <= 2'd0;
      r_rd_pend <= 1'b0;
    end else begin
      // Counter parks on the last address so the fill never wraps.
      if (r_state == CLEAR && r_clr_cnt != CLR_LAST) r_clr_cnt <= r_clr_cnt + 1'b1;
      r_rd_pend <= w_rd_accept;
      case ({w_rd_accept, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Read data arrives one cycle after the read address and is pushed while rd_pend is set.
  ram_rsp_fifo2 #(
    .D_WIDTH (D_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_rd_pend),
    .push_data (mem_r_data),
    .pop       (rsp_ready),
    .valid     (rsp_valid),
    .full      (w_fifo_full),
    .data      (rsp_data)
  );

  // Occupancy limit keeps the FIFO from ever seeing a push while full.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(r_rd_pend && w_fifo_full));

endmodule

// File: tb/tb_ram_port_initiator.sv
// Directed bench for ram_port_initiator with a behavioural synchronous RAM attached.
module tb_ram_port_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_done;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [2:0] cmd_add;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       mem_we;
  logic [2:0] mem_w_add;
  logic [7:0] mem_w_data;
  logic [2:0] mem_r_add;
  logic [7:0] mem_r_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram [8];
  logic [7:0] model [8];

  ram_port_initiator #(.A_WIDTH(3), .D_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_add    (cmd_add),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .mem_we     (mem_we),
    .mem_w_add  (mem_w_add),
    .mem_w_data (mem_w_data),
    .mem_r_add  (mem_r_add),
    .mem_r_data (mem_r_data)
  );

  always #5 clk = ~clk;

  // RAM outside the DUT: write port plus registered read port.
  always @(posedge clk) begin
    if (mem_we) ram[mem_w_add] <= mem_w_data;
    mem_r_data <= ram[mem_r_add];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_add = 3'd0; cmd_data = 8'd0; rsp_ready = 1'b0;
    cyc(); cyc();
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL fill_we[%0d] got=%b exp=1", i, mem_we); end
      total++; if (mem_w_add !== 3'(i)) begin bad++; $display("FAIL fill_add[%0d] got=%0d exp=%0d", i, mem_w_add, i); end
      total++; if (mem_w_data !== 8'h00) begin bad++; $display("FAIL fill_data[%0d] got=%h exp=00", i, mem_w_data); end
      total++; if (cmd_ready !== 1'b0 || init_done !== 1'b0) begin bad++; $display("FAIL fill_ready[%0d] got=%b/%b exp=0/0", i, cmd_ready, init_done); end
      $display("fill cycle %0d addr=%0d", i, mem_w_add);
      cyc();
    end
    #1;
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL done_init got=%b exp=1", init_done); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL done_ready got=%b exp=1", cmd_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL done_we got=%b exp=0", mem_we); end
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  task automatic test_write_read();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_add = 3'd3; cmd_data = 8'hA5; rsp_ready = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", cmd_ready); end
    total++; if ({mem_we, mem_w_add, mem_w_data} !== {1'b1, 3'd3, 8'hA5}) begin bad++; $display("FAIL wr_port got=%b/%0d/%h exp=1/3/a5", mem_we, mem_w_add, mem_w_data); end
    $display("write add=3 data=a5");
    model[3] = 8'hA5;
    cyc();
    cmd_wr = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL rd_accept got=%b/%b exp=1/0", cmd_ready, mem_we); end
    total++; if (mem_r_add !== 3'd3) begin bad++; $display("FAIL rd_add got=%0d exp=3", mem_r_add); end
    cyc();
    cmd_valid = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_lat1 got=%b exp=0", rsp_valid); end
    cyc(); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin bad++; $display("FAIL rd_lat2 got=%b/%h exp=1/a5", rsp_valid, rsp_data); end
    $display("rsp data=%h", rsp_data);
    cyc(); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_one_beat got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] wd [3];
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_add = 3'(i + 1); cmd_data = wd[i]; rsp_ready = 1'b0;
      #1;
      total++; if (cmd_ready !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL bp_wr[%0d] got=%b/%b exp=1/1", i, cmd_ready, mem_we); end
      model[i + 1] = wd[i];
      cyc();
    end
    // r0: read @1
    cmd_wr = 1'b0; cmd_add = 3'd1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_r0_ready got=%b exp=1", cmd_ready); end
    cyc();
    // r1: read @2
    cmd_add = 3'd2;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_r1_ready got=%b exp=1", cmd_ready); end
    cyc();
    // r2: read @3 is stalled
    cmd_add = 3'd3;
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_r2_ready got=%b exp=0", cmd_ready); end
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h11) begin bad++; $display("FAIL bp_r2_rsp got=%b/%h exp=1/11", rsp_valid, rsp_data); end
    cyc(); #1;
    total++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'h11) begin bad++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/11", cmd_ready, rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    $display("rsp data=%h", rsp_data);
    cyc(); #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_r4_ready got=%b exp=1", cmd_ready); end
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h22) begin bad++; $display("FAIL bp_r4_rsp got=%b/%h exp=1/22", rsp_valid, rsp_data); end
    $display("rsp data=%h", rsp_data);
    cyc();
    cmd_valid = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_r5_empty got=%b exp=0", rsp_valid); end
    cyc(); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h33) begin bad++; $display("FAIL bp_r6_rsp got=%b/%h exp=1/33", rsp_valid, rsp_data); end
    $display("rsp data=%h", rsp_data);
    cyc(); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_r7_empty got=%b exp=0", rsp_valid); end
  endtask

  // Reads 0..7 back-to-back with rsp_ready held high.
  task automatic test_stream();
    logic [7:0] exp_q [$];
    int issued = 0, got = 0, outst = 0, cycle = 0, first_acc = -1, last_acc = -1;
    while (got < 8 && cycle < 100) begin
      cmd_valid = (issued < 8); cmd_wr = 1'b0; cmd_add = 3'(issued); rsp_ready = 1'b1;
      #1;
      total++; if (cmd_ready !== (outst < 2)) begin bad++; $display("FAIL st_ready[c%0d] got=%b exp=%b", cycle, cmd_ready, outst < 2); end
      if (rsp_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL st_stale got=%h exp=none", rsp_data); end
        else begin
          if (rsp_data !== exp_q[0]) begin bad++; $display("FAIL st_data[%0d] got=%h exp=%h", got, rsp_data, exp_q[0]); end
          $display("rsp %0d data=%h", got, rsp_data);
          void'(exp_q.pop_front()); outst--; got++;
        end
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        exp_q.push_back(model[cmd_add]); outst++; issued++;
        if (first_acc < 0) first_acc = cycle;
        last_acc = cycle;
      end
      cyc(); cycle++;
    end
    cmd_valid = 1'b0;
    total++; if (got != 8) begin bad++; $display("FAIL st_count got=%0d exp=8", got); end
    total++; if (last_acc - first_acc != 10) begin bad++; $display("FAIL st_rate got=%0d exp=10", last_acc - first_acc); end
  endtask

  task automatic test_reset_midop();
    // Leave nonzero data so the repeated fill is observable.
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_add = (i == 0) ? 3'd0 : 3'd7; cmd_data = 8'h5A; rsp_ready = 1'b0;
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      cmd_wr = 1'b0; cmd_add = (i == 0) ? 3'd0 : 3'd7;
      #1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mr_rd_ready[%0d] got=%b exp=1", i, cmd_ready); end
      cyc();
    end
    cmd_valid = 1'b0; reset = 1'b1;
    cyc();
    total++; if (rsp_valid !== 1'b0 || init_done !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL mr_flush got=%b/%b/%b exp=0/0/0", rsp_valid, init_done, cmd_ready); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (mem_we !== 1'b1 || mem_w_add !== 3'(i) || mem_w_data !== 8'h00) begin bad++; $display("FAIL mr_fill[%0d] got=%b/%0d/%h exp=1/%0d/00", i, mem_we, mem_w_add, mem_w_data, i); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mr_stale[%0d] got=%b exp=0", i, rsp_valid); end
      cyc();
    end
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_add = 3'd0; rsp_ready = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1 || init_done !== 1'b1) begin bad++; $display("FAIL mr_run got=%b/%b exp=1/1", cmd_ready, init_done); end
    cyc();
    cmd_add = 3'd7;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mr_no_stale got=%b exp=0", rsp_valid); end
    cyc();
    cmd_valid = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin bad++; $display("FAIL mr_rd0 got=%b/%h exp=1/00", rsp_valid, rsp_data); end
    cyc(); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin bad++; $display("FAIL mr_rd7 got=%b/%h exp=1/00", rsp_valid, rsp_data); end
    cyc(); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mr_end got=%b exp=0", rsp_valid); end
  endtask

  // Mixed traffic and random response backpressure against the reference array.
  task automatic test_random();
    logic [7:0] exp_q [$];
    int outst = 0, got = 0, cycle = 0;
    while (cycle < 600 && !(cycle >= 300 && outst == 0)) begin
      if (cycle < 300) begin
        cmd_valid = 1'($urandom_range(0, 1)); cmd_wr = 1'($urandom_range(0, 1));
        cmd_add = 3'($urandom_range(0, 7)); cmd_data = 8'($urandom_range(0, 255));
        rsp_ready = 1'($urandom_range(0, 2) != 0);
      end else begin
        cmd_valid = 1'b0; rsp_ready = 1'b1;
      end
      #1;
      total++; if (cmd_ready !== (outst < 2)) begin bad++; $display("FAIL rnd_ready[c%0d] got=%b exp=%b", cycle, cmd_ready, outst < 2); end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_stale got=%h exp=none", rsp_data); end
        else begin
          if (rsp_data !== exp_q[0]) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", got, rsp_data, exp_q[0]); end
          $display("rsp %0d data=%h", got, rsp_data);
          void'(exp_q.pop_front()); outst--; got++;
        end
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        if (cmd_wr) model[cmd_add] = cmd_data;
        else begin exp_q.push_back(model[cmd_add]); outst++; end
      end
      cyc(); cycle++;
    end
    total++; if (outst != 0) begin bad++; $display("FAIL rnd_drain got=%0d exp=0", outst); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_write_read();
    test_backpressure();
    test_stream();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
